fp_addsub_seq: RTL and testbench
================================

# fp_addsub_seq

Multi-cycle sequencer for IEEE 754 single-precision add/subtract. Accepts two operands and an `opp` select over a valid/ready handshake. Applies the subtract sign-flip to B internally, then steps one shared 25-bit mantissa adder/shifter through unpack, align, add, normalize and pack. It sits between the operand-issue logic and the result writeback in the FP unit and trades latency for area: no barrel shifters, one adder.

## Interface
Parameters:
- none; all widths come from the shared package.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands (IDLE only).
- `opp`  in  1  1 = A − B, 0 = A + B.
- `flt_A`  in  32  operand A.
- `flt_B`  in  32  operand B.
- `out_valid`  out  1  result present (DONE only).
- `out_ready`  in  1  consumer takes result.
- `flt_out`  out  32  result; held stable while `out_valid` is high.

## Operation
States: IDLE, UNPACK, ALIGN, ADD, NORM, DONE. Each state occupies whole cycles.

**IDLE**
- `in_ready` = 1.
- On `in_valid`: capture A, and capture B with sign = `B[31] ^ opp`. Go to UNPACK.

**UNPACK**
- Exp = 0 (zero or denormal) is treated as signed zero (flush).
- Any NaN input, or Inf + Inf with opposite effective signs → 0x7FC00000, go to DONE.
- Otherwise any Inf → that Inf with its effective sign, go to DONE.
- Otherwise form 24-bit mantissas with the hidden bit.
- Swap the operands if |B| > |A|, comparing {exp, frac}. Equal magnitudes: no swap.
- diff = expA − expB. If diff ≥ 25: mB = 0, diff = 0.
- diff = 0 → ADD; else → ALIGN.

**ALIGN**
- Each cycle: mB >>= 1, diff −= 1. Shifted-out bits are lost (truncation).
- Go to ADD when diff reaches 0.

**ADD**
- Signs equal: sum = mA + mB (25 bits). Signs differ: sum = mA − mB, which is never negative.
- Result sign = sign of A (the larger operand).
- sum = 0 → 0x00000000, go to DONE.
- Else → NORM.

**NORM**, one action per cycle, checked in this order:
- `sum[24]` set: sum >>= 1, exp += 1. If exp becomes 255, result = Inf with sign, go to DONE.
- `sum[23]` clear: sum <<= 1, exp −= 1. If exp reaches 0, result = signed zero, go to DONE.
- Otherwise pack {sign, exp, sum[22:0]} and go to DONE.

**DONE**
- `out_valid` = 1 and `flt_out` is held.
- On `out_ready`: go to IDLE.

Rounding is round-toward-zero throughout.

## Timing
- While `rst_n` = 0 (sampled at the edge): state = IDLE, `in_ready` = 0, `out_valid` = 0, `flt_out` = 0. `in_ready` rises in the first cycle after release.
- Reset mid-operation aborts immediately. The result is discarded and `out_valid` never pulses.
- Latency from the accepting edge to the first cycle of `out_valid`: 4 + align_cycles + norm_shifts, with align_cycles ≤ 24. Special cases (UNPACK → DONE) take 2.
- `in_ready` is low from UNPACK through DONE. `in_valid` in those states is ignored; the operands are not queued.
- `out_valid` with `out_ready` low: hold `flt_out` indefinitely.
- Handshake and next accept: when `out_valid & out_ready`, the block is in IDLE on the next cycle. At most one operation is in flight at a time.

## Structure
- Package `fp_pkg`:
  - EXP_W = 8, FRAC_W = 23, BIAS = 127, EXP_MAX = 255.
  - QNAN = 32'h7FC00000.
  - State enum.
  - Unpacked-operand struct {sign, exp, mant[23:0], is_zero, is_inf, is_nan}.
- Sub-module `fp_unpack`: combinational classify/unpack of one 32-bit word. Instantiated twice.
- The FSM, swap logic, shifter and adder live in the top.

## Test plan
- 0x3F800000 + 0x3F800000, opp = 0 → 0x40000000. `out_valid` 5 cycles after accept (one right-shift in NORM).
- 0x40400000 − 0x3F800000, opp = 1 → 0x40000000. 0x3F800000 − 0x3F800000 → 0x00000000.
- 0x3F800000 + 0x35800000 → 0x3F800008 after 20 ALIGN cycles, latency 24. 0x3F800000 + 0x33000000 (diff 25) → 0x3F800000.
- 0x7F800000 + 0xFF800000 → 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 10 cycles, and toggle `in_valid` with new operands during that time.
  - Required: `flt_out` stable, `in_ready` = 0, new operands ignored; the next result is computed only after the handshake.
- Reset during ALIGN:
  - Stimulus: start the 0x3F800000 + 0x35800000 case and pull `rst_n` low mid-ALIGN.
  - Required: `out_valid` never asserts, `in_ready` = 1 one cycle after release, and a fresh 1.0 + 1.0 returns 0x40000000.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: widths, constants, FSM states and the unpacked-operand record shared by the FP add/sub slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    localparam int WORD_W = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;   // with hidden bit
    localparam int SUM_W  = MANT_W + 1;   // one carry bit
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0]  EXP_MAX    = 8'd255;
    // Alignment distance at which the smaller operand is dropped entirely.
    localparam logic [EXP_W-1:0]  FLUSH_DIFF = 8'd25;
    localparam logic [WORD_W-1:0] QNAN       = 32'h7FC00000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } unpk_t;

endpackage

// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if: operand-issue and result-writeback handshakes of the sequential FP add/sub.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; master issues operands and consumes the result.
interface fp_addsub_seq_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              opp;
    logic [WORD_W-1:0] flt_A;
    logic [WORD_W-1:0] flt_B;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] flt_out;

    modport master (
        output in_valid, opp, flt_A, flt_B, out_ready,
        input  in_ready, out_valid, flt_out
    );

    modport slave (
        input  in_valid, opp, flt_A, flt_B, out_ready,
        output in_ready, out_valid, flt_out
    );

endinterface

// File: rtl/fp_unpack.sv
// fp_unpack: classify one single-precision word and expand its significand with the hidden bit.
// Latency: combinational.
// Backpressure: none.
// Ports: word (32-bit operand in), op (unpacked record out). Zero and denormal inputs flush to signed zero.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output unpk_t             op
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    logic              zero_f;

    assign exp_f  = word[WORD_W-2 -: EXP_W];
    assign frac_f = word[FRAC_W-1:0];
    assign zero_f = (exp_f == '0);

    always_comb begin
        op         = '0;
        op.sign    = word[WORD_W-1];
        op.is_zero = zero_f;
        op.is_inf  = (exp_f == EXP_MAX) && (frac_f == '0);
        op.is_nan  = (exp_f == EXP_MAX) && (frac_f != '0);
        // Denormals keep exp = 0 and mant = 0, i.e. behave as signed zero.
        if (!zero_f) begin
            op.exp  = exp_f;
            op.mant = {1'b1, frac_f};
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single add/subtract stepping one 25-bit adder/shifter, round toward zero.
// Latency: 4 + align shifts + normalise shifts from the accepting edge to out_valid; NaN/Inf cases take 2.
// Backpressure: accepts only in IDLE (no queueing); the result is held in DONE until out_ready.
// Ports: clk, rst_n (synchronous, active-low), io (slave modport: in_valid/in_ready/opp/flt_A/flt_B, out_valid/out_ready/flt_out).
module fp_addsub_seq
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    fp_addsub_seq_if.slave  io
);

    state_t state, state_nxt;

    logic              in_ready_q;
    logic [WORD_W-1:0] a_raw, b_raw;
    logic [WORD_W-1:0] res;

    logic              sign_a, sign_b;
    logic [EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic [4:0]        diff;
    logic [SUM_W-1:0]  sum;

    unpk_t ua, ub;

    fp_unpack u_unpack_a (.word(a_raw), .op(ua));
    fp_unpack u_unpack_b (.word(b_raw), .op(ub));

    // ---------------- UNPACK: specials, ordering, alignment distance ----------------
    logic              nan_hit, inf_hit, special;
    logic [WORD_W-1:0] special_word;
    logic              swap;
    logic              big_sign, small_sign, small_zero;
    logic [EXP_W-1:0]  big_exp, small_exp, exp_diff;
    logic [MANT_W-1:0] big_mant, small_mant, mant_b_init;
    logic              far;
    logic [4:0]        diff_init;

    assign nan_hit = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & (ua.sign ^ ub.sign));
    assign inf_hit = ua.is_inf | ub.is_inf;
    assign special = nan_hit | inf_hit;

    always_comb begin
        special_word = QNAN;
        if (!nan_hit) begin
            if (ua.is_inf) special_word = {ua.sign, EXP_MAX, {FRAC_W{1'b0}}};
            else           special_word = {ub.sign, EXP_MAX, {FRAC_W{1'b0}}};
        end
    end

    // Equal magnitudes keep A first, so an exact cancellation takes A's sign path.
    assign swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};

    assign big_sign   = swap ? ub.sign    : ua.sign;
    assign big_exp    = swap ? ub.exp     : ua.exp;
    assign big_mant   = swap ? ub.mant    : ua.mant;
    assign small_sign = swap ? ua.sign    : ub.sign;
    assign small_exp  = swap ? ua.exp     : ub.exp;
    assign small_mant = swap ? ua.mant    : ub.mant;
    assign small_zero = swap ? ua.is_zero : ub.is_zero;

    assign exp_diff    = big_exp - small_exp;
    assign far         = (exp_diff >= FLUSH_DIFF);
    assign diff_init   = far ? 5'd0 : exp_diff[4:0];
    assign mant_b_init = (far || small_zero) ? '0 : small_mant;

    // ---------------- shared adder and exponent stepping ----------------
    logic [SUM_W-1:0] sum_add;
    logic [EXP_W-1:0] exp_inc, exp_dec;

    // Operands are ordered by magnitude, so the difference never goes negative.
    assign sum_add = (sign_a ^ sign_b) ? ({1'b0, mant_a} - {1'b0, mant_b})
                                       : ({1'b0, mant_a} + {1'b0, mant_b});
    assign exp_inc = exp_r + 8'd1;
    assign exp_dec = exp_r - 8'd1;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (io.in_valid && in_ready_q) state_nxt = ST_UNPACK;
            ST_UNPACK: begin
                if (special)                state_nxt = ST_DONE;
                else if (diff_init == 5'd0) state_nxt = ST_ADD;
                else                        state_nxt = ST_ALIGN;
            end
            ST_ALIGN:  if (diff == 5'd1) state_nxt = ST_ADD;
            ST_ADD:    state_nxt = (sum_add == '0) ? ST_DONE : ST_NORM;
            ST_NORM: begin
                if (sum[SUM_W-1]) begin
                    if (exp_inc == EXP_MAX) state_nxt = ST_DONE;
                end else if (!sum[MANT_W-1]) begin
                    if (exp_dec == '0) state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:   if (io.out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
            a_raw      <= '0;
            b_raw      <= '0;
            res        <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            exp_r      <= '0;
            mant_a     <= '0;
            mant_b     <= '0;
            diff       <= '0;
            sum        <= '0;
        end else begin
            // Registered so in_ready stays low through the reset cycles themselves.
            in_ready_q <= (state_nxt == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (io.in_valid && in_ready_q) begin
                        a_raw <= io.flt_A;
                        b_raw <= {io.flt_B[WORD_W-1] ^ io.opp, io.flt_B[WORD_W-2:0]};
                    end
                end
                ST_UNPACK: begin
                    if (special) res <= special_word;
                    sign_a <= big_sign;
                    sign_b <= small_sign;
                    exp_r  <= big_exp;
                    mant_a <= big_mant;
                    mant_b <= mant_b_init;
                    diff   <= diff_init;
                end
                ST_ALIGN: begin
                    mant_b <= mant_b >> 1;
                    diff   <= diff - 5'd1;
                end
                ST_ADD: begin
                    sum <= sum_add;
                    if (sum_add == '0) res <= '0;
                end
                ST_NORM: begin
                    if (sum[SUM_W-1]) begin
                        sum   <= sum >> 1;
                        exp_r <= exp_inc;
                        if (exp_inc == EXP_MAX) res <= {sign_a, EXP_MAX, {FRAC_W{1'b0}}};
                    end else if (!sum[MANT_W-1]) begin
                        sum   <= sum << 1;
                        exp_r <= exp_dec;
                        if (exp_dec == '0) res <= {sign_a, {(WORD_W-1){1'b0}}};
                    end else begin
                        res <= {sign_a, exp_r, sum[FRAC_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = (state == ST_DONE);
    assign io.flt_out   = res;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed and random add/subtract vectors against an arithmetic reference model.
// Latency: n/a.
// Backpressure: exercises held results with out_ready low and ignored operands while busy.
module tb_fp_addsub_seq;
    import fp_pkg::*;

    logic clk;
    logic rst_n;

    fp_addsub_seq_if io ();

    fp_addsub_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t dir_tab [10] = '{
        '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000,  5},
        '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000,  5},
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000,  3},
        '{32'h3F800000, 32'h35800000, 1'b0, 32'h3F800008, 24},
        '{32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000,  4},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000,  2},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000,  4},
        '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000,  5},
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000,  2},
        '{32'h00000001, 32'h80000000, 1'b0, 32'h00000000,  3}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    // Reference: decode, order by magnitude, truncating align, exact add, then
    // normalise with exponent limits; latency follows the state sequence rules.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b_in,
                                      input logic op, output logic [31:0] r, output int lat);
        logic [31:0] b;
        logic        sa, sb, st;
        int          ea, eb, et, d, k, msb;
        longint      ma, mb, mt, sum;
        bit          na, nb, ia, ib;
        b  = {b_in[31] ^ op, b_in[30:0]};
        sa = a[31];
        sb = b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        lat = 2;
        if (na || nb || (ia && ib && (sa != sb))) begin r = QNAN; return; end
        if (ia) begin r = {sa, 8'hFF, 23'd0}; return; end
        if (ib) begin r = {sb, 8'hFF, 23'd0}; return; end
        ma = (ea == 0) ? 0 : longint'(a[22:0]) + longint'(32'h800000);
        mb = (eb == 0) ? 0 : longint'(b[22:0]) + longint'(32'h800000);
        if ((eb > ea) || ((eb == ea) && (mb > ma))) begin
            st = sa; sa = sb; sb = st;
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        d = ea - eb;
        if (d >= 25) begin mb = 0; d = 0; end
        mb  = mb >> d;
        sum = (sa == sb) ? ma + mb : ma - mb;
        lat = 3 + d;
        if (sum == 0) begin r = 32'h0; return; end
        msb = 0;
        for (int i = 0; i < 25; i++) if (sum[i]) msb = i;
        if (msb == 24) begin
            if (ea + 1 == int'(EXP_MAX)) begin
                r = {sa, 8'hFF, 23'd0};
                lat += 1;
            end else begin
                r = {sa, 8'(ea + 1), 23'(sum >> 1)};
                lat += 2;
            end
        end else begin
            k = 23 - msb;
            if (ea <= k) begin
                r = {sa, 31'd0};
                lat += ea;
            end else begin
                r = {sa, 8'(ea - k), 23'(sum << k)};
                lat += k + 1;
            end
        end
    endfunction

    function automatic logic [31:0] rnd_word(input int ebase);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        int          sel;
        s   = 1'($urandom);
        f   = 23'($urandom);
        sel = int'($urandom_range(0, 19));
        if (sel == 0)      begin e = 8'hFF; f = 23'd0; end
        else if (sel == 1) begin e = 8'hFF; f = f | 23'd1; end
        else if (sel == 2) e = 8'h00;
        else if (sel == 3) e = 8'($urandom_range(240, 254));
        else               e = 8'(ebase + int'($urandom_range(0, 30)) - 15);
        return {s, e, f};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op);
        int n;
        n = 0;
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        io.in_valid = 1'b1;
        io.flt_A    = a;
        io.flt_B    = b;
        io.opp      = op;
        @(posedge clk);
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    // lat counts the accepting edge as 1; a timeout shows up as lat = 300.
    task automatic wait_done(output logic [31:0] res, output int lat);
        lat = 1;
        while (!io.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        res = io.flt_out;
    endtask

    task automatic take();
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic op, input logic [31:0] exp_r, input int exp_lat);
        logic [31:0] got;
        int          gl;
        issue(a, b, op);
        wait_done(got, gl);
        check({tag, "_res"}, got, exp_r);
        check({tag, "_lat"}, 32'(gl), 32'(exp_lat));
        take();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, er;
        logic        rop;
        int          el, ebase;
        bit          saw_valid;

        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.opp       = 1'b0;
        io.flt_A     = '0;
        io.flt_B     = '0;
        io.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(io.in_ready),  32'd0);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_flt_out",   io.flt_out,        32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(io.in_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 10; i++)
            run_case($sformatf("dir%0d", i), dir_tab[i].a, dir_tab[i].b, dir_tab[i].op,
                     dir_tab[i].r, dir_tab[i].lat);

        // Backpressure: result held, busy block ignores new operands
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        wait_done(er, el);
        check("bp_res", er, 32'h40000000);
        for (int i = 0; i < 10; i++) begin
            io.in_valid = 1'(i % 2 == 0);
            io.flt_A    = $urandom;
            io.flt_B    = $urandom;
            io.opp      = 1'($urandom);
            @(negedge clk);
            check($sformatf("bp_hold%0d", i),  io.flt_out,        32'h40000000);
            check($sformatf("bp_rdy%0d", i),   32'(io.in_ready),  32'd0);
            check($sformatf("bp_vld%0d", i),   32'(io.out_valid), 32'd1);
        end
        io.in_valid = 1'b0;
        take();
        check("bp_after_vld", 32'(io.out_valid), 32'd0);
        check("bp_after_rdy", 32'(io.in_ready),  32'd1);
        run_case("bp_next", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 6);

        // Reset during ALIGN
        issue(32'h3F800000, 32'h35800000, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("ra_rst_vld", 32'(io.out_valid), 32'd0);
        check("ra_rst_rdy", 32'(io.in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ra_rel_rdy", 32'(io.in_ready), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (io.out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        check("ra_no_valid", 32'(saw_valid), 32'd0);
        run_case("ra_fresh", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5);

        // Random vectors against the reference model
        for (int i = 0; i < 80; i++) begin
            ebase = BIAS + int'($urandom_range(0, 40)) - 20;
            ra    = rnd_word(ebase);
            rb    = rnd_word(ebase);
            rop   = 1'($urandom);
            if (i % 4 == 0) begin
                // Near-cancellation: same magnitude region, opposite effective sign.
                rb     = ra ^ {9'd0, 23'($urandom_range(0, 255))};
                rb[31] = ~ra[31] ^ rop;
            end
            ref_model(ra, rb, rop, er, el);
            run_case($sformatf("rnd%0d", i), ra, rb, rop, er, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
